wbuf_pingpong_sched: RTL and testbench

Scheduler that splits the unified weight buffer into two halves, A and B, and runs them as a ping-pong pair.
- While layer L executes from one half, it issues a DMA preload of layer L+1's weights into the other half.
- It gates layer_exec's start until that layer's weights are resident.
- It sits between the top-level layer FSM, the DMA preload controller and layer_exec. It replaces direct start wiring so that weight load overlaps compute.

---
 rtl/wbuf_pingpong_sched_pkg.sv | 11 +
 rtl/wbuf_pingpong_sched_if.sv | 30 +++
 rtl/wbuf_pingpong_sched_pf_slot.sv | 49 ++++
 rtl/wbuf_pingpong_sched.sv | 111 +++++++++++
 tb/tb_wbuf_pingpong_sched.sv | 127 ++++++++++++
 5 files changed

// File: rtl/wbuf_pingpong_sched_pkg.sv
// wsched_pkg: shared widths, FSM state encoding and half-buffer base helper for the weight-buffer ping-pong scheduler
package wsched_pkg;
  localparam int ADDR_W     = 16;
  localparam int CNT_W      = 17;
  localparam int BUF_ADDR_W = 13;
  localparam int HALF_WORDS = 4096;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_EXEC, S_DRAIN, S_FIN} state_t;
  function automatic logic [BUF_ADDR_W-1:0] half_base(input logic h);
    return h ? BUF_ADDR_W'(HALF_WORDS) : '0;
  endfunction
endpackage

// File: rtl/wbuf_pingpong_sched_if.sv
// wsched_if: scheduler bundle between top FSM, DMA preload controller and layer_exec
// master = scheduler (drives pf_*, exec_*, busy, sched_done, err_oversize); slave = surrounding blocks
interface wsched_if;
  import wsched_pkg::*;
  logic                  run_start;
  logic                  layer_done;
  logic                  last_layer;
  logic [ADDR_W-1:0]     cur_w_base;
  logic [CNT_W-1:0]      cur_w_count;
  logic [ADDR_W-1:0]     nxt_w_base;
  logic [CNT_W-1:0]      nxt_w_count;
  logic                  pf_req;
  logic [ADDR_W-1:0]     pf_base;
  logic [CNT_W-1:0]      pf_count;
  logic [BUF_ADDR_W-1:0] pf_dst;
  logic                  pf_done;
  logic                  exec_start;
  logic                  exec_half;
  logic                  busy;
  logic                  sched_done;
  logic                  err_oversize;
  modport master (
    input  run_start, layer_done, last_layer, cur_w_base, cur_w_count, nxt_w_base, nxt_w_count, pf_done,
    output pf_req, pf_base, pf_count, pf_dst, exec_start, exec_half, busy, sched_done, err_oversize
  );
  modport slave (
    output run_start, layer_done, last_layer, cur_w_base, cur_w_count, nxt_w_base, nxt_w_count, pf_done,
    input  pf_req, pf_base, pf_count, pf_dst, exec_start, exec_half, busy, sched_done, err_oversize
  );
endinterface

// File: rtl/wbuf_pingpong_sched_pf_slot.sv
// wsched_pf_slot: one outstanding preload request with issued/ready tracking and count clamping
// Ports: CLK/RESETn; i_load latches a request (base/count/half), i_clear drops issued/ready,
// i_done is the DMA completion pulse; o_req/o_base/o_count/o_dst drive the DMA, o_err is sticky oversize.
module wsched_pf_slot
  import wsched_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic                  i_half,
  input  logic [ADDR_W-1:0]     i_base,
  input  logic [CNT_W-1:0]      i_count,
  input  logic                  i_done,
  output logic                  o_req,
  output logic                  o_issued,
  output logic                  o_ready,
  output logic [ADDR_W-1:0]     o_base,
  output logic [CNT_W-1:0]      o_count,
  output logic [BUF_ADDR_W-1:0] o_dst,
  output logic                  o_err
);
  logic w_over;
  assign w_over = i_count > CNT_W'(HALF_WORDS);
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      o_req    <= 1'b0;
      o_issued <= 1'b0;
      o_ready  <= 1'b0;
      o_base   <= '0;
      o_count  <= '0;
      o_dst    <= '0;
      o_err    <= 1'b0;
    end else begin
      if (i_load) begin
        o_req   <= 1'b1;
        o_base  <= i_base;
        o_count <= w_over ? CNT_W'(HALF_WORDS) : i_count;
        o_dst   <= half_base(i_half);
      end else if (i_done) begin
        o_req <= 1'b0;
      end
      o_issued <= i_clear ? 1'b0 : (o_issued | i_load);
      // completion only counts while a request is outstanding
      o_ready  <= i_clear ? 1'b0 : (o_ready | (o_req & i_done));
      o_err    <= o_err | (i_load & w_over);
    end
  end
endmodule

// File: rtl/wbuf_pingpong_sched.sv
// wbuf_pingpong_sched: ping-pong weight-buffer scheduler overlapping layer L+1 preload with layer L compute
// Ports: CLK, RESETn (async active-low); bus (wsched_if.master) carries run/layer control from the top FSM,
// the pf_* preload handshake to the DMA controller and exec_start/exec_half to layer_exec.
module wbuf_pingpong_sched
  import wsched_pkg::*;
(
  input  logic      CLK,
  input  logic      RESETn,
  wsched_if.master  bus
);
  state_t                r_state;
  logic                  r_exec_start;
  logic                  r_exec_half;
  logic                  r_busy;
  logic                  r_sched_done;
  logic                  w_req;
  logic                  w_issued;
  logic                  w_ready;
  logic [ADDR_W-1:0]     w_base;
  logic [CNT_W-1:0]      w_count;
  logic [BUF_ADDR_W-1:0] w_dst;
  logic                  w_err;
  logic                  w_ack;
  logic                  w_nxt_zero;
  logic                  w_go;
  logic                  w_want;
  logic                  w_fill;
  logic                  w_load;
  logic                  w_clear;
  assign w_ack      = bus.pf_done & w_req;
  assign w_nxt_zero = bus.nxt_w_count == '0;
  // next layer may start now: preload finished earlier, finishes this cycle, or is not needed
  assign w_go       = w_ready | w_ack | w_nxt_zero;
  // DRAIN may also issue, covering a layer_done that beat the prefetch issue
  assign w_want     = !w_issued && !bus.last_layer && !w_nxt_zero &&
                      ((r_state == S_EXEC && !bus.layer_done) || r_state == S_DRAIN);
  assign w_fill     = r_state == S_IDLE && bus.run_start && bus.cur_w_count != '0;
  assign w_load     = w_fill | w_want;
  assign w_clear    = (r_state == S_FILL && w_ack) || (r_state == S_DRAIN && w_ack) ||
                      (r_state == S_EXEC && bus.layer_done && (bus.last_layer || w_go));
  wsched_pf_slot u_slot (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .i_load   (w_load),
    .i_clear  (w_clear),
    .i_half   (w_fill ? 1'b0 : ~r_exec_half),
    .i_base   (w_fill ? bus.cur_w_base : bus.nxt_w_base),
    .i_count  (w_fill ? bus.cur_w_count : bus.nxt_w_count),
    .i_done   (bus.pf_done),
    .o_req    (w_req),
    .o_issued (w_issued),
    .o_ready  (w_ready),
    .o_base   (w_base),
    .o_count  (w_count),
    .o_dst    (w_dst),
    .o_err    (w_err)
  );
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state      <= S_IDLE;
      r_exec_start <= 1'b0;
      r_exec_half  <= 1'b0;
      r_busy       <= 1'b0;
      r_sched_done <= 1'b0;
    end else begin
      r_exec_start <= 1'b0;
      r_sched_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.run_start) begin
          r_busy      <= 1'b1;
          r_exec_half <= 1'b0;
          r_state     <= w_fill ? S_FILL : S_EXEC;
          r_exec_start <= !w_fill;
        end
        S_FILL: if (w_ack) begin
          r_state      <= S_EXEC;
          r_exec_start <= 1'b1;
        end
        S_EXEC: if (bus.layer_done) begin
          if (bus.last_layer) begin
            r_state      <= S_FIN;
            r_sched_done <= 1'b1;
            r_busy       <= 1'b0;
          end else if (w_go) begin
            r_exec_start <= 1'b1;
            // a layer without weights reuses the current half
            r_exec_half  <= r_exec_half ^ w_issued;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: if (w_ack) begin
          r_state      <= S_EXEC;
          r_exec_start <= 1'b1;
          r_exec_half  <= ~r_exec_half;
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.pf_req       = w_req;
  assign bus.pf_base      = w_base;
  assign bus.pf_count     = w_count;
  assign bus.pf_dst       = w_dst;
  assign bus.exec_start   = r_exec_start;
  assign bus.exec_half    = r_exec_half;
  assign bus.busy         = r_busy;
  assign bus.sched_done   = r_sched_done;
  assign bus.err_oversize = w_err;
endmodule

// File: tb/tb_wbuf_pingpong_sched.sv
// tb_wbuf_pingpong_sched: directed self-checking bench for the ping-pong weight scheduler
module tb_wbuf_pingpong_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int n_start;
  wsched_if bus();
  wbuf_pingpong_sched dut (.CLK(clk), .RESETn(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // {pf_req, exec_start, exec_half, busy, sched_done, err_oversize}
  function automatic logic [31:0] flags();
    return {26'd0, bus.pf_req, bus.exec_start, bus.exec_half, bus.busy, bus.sched_done, bus.err_oversize};
  endfunction
  task automatic set_nxt(input logic [15:0] b, input logic [16:0] c);
    bus.nxt_w_base = b;
    bus.nxt_w_count = c;
  endtask
  initial begin
    bus.run_start = 0; bus.layer_done = 0; bus.last_layer = 0; bus.pf_done = 0;
    bus.cur_w_base = 0; bus.cur_w_count = 0; set_nxt(0, 0);
    tick(); tick();
    chk("reset_flags", flags(), 32'h0);
    chk("reset_dst", 32'(bus.pf_dst), 32'd0);
    rst_n = 1'b1;
    // FILL of first layer into half A
    bus.cur_w_base = 16'h0100; bus.cur_w_count = 17'd300; set_nxt(16'h0200, 17'd1000);
    bus.run_start = 1; tick(); bus.run_start = 0;
    chk("fill_flags", flags(), 32'b100100);
    chk("fill_base", 32'(bus.pf_base), 32'h0100);
    chk("fill_count", 32'(bus.pf_count), 32'd300);
    chk("fill_dst", 32'(bus.pf_dst), 32'd0);
    bus.layer_done = 1; tick(); bus.layer_done = 0;
    chk("fill_ignores_layer_done", flags(), 32'b100100);
    repeat (5) tick();
    bus.pf_done = 1; tick(); bus.pf_done = 0;
    chk("fill_done_start", flags(), 32'b010100);
    tick();
    chk("pf1_flags", flags(), 32'b100100);
    chk("pf1_base", 32'(bus.pf_base), 32'h0200);
    chk("pf1_count", 32'(bus.pf_count), 32'd1000);
    chk("pf1_dst", 32'(bus.pf_dst), 32'd4096);
    repeat (3) tick();
    bus.pf_done = 1; tick(); bus.pf_done = 0;
    chk("pf1_done", flags(), 32'b000100);
    repeat (3) tick();
    bus.layer_done = 1; tick(); bus.layer_done = 0;
    chk("ready_restart", flags(), 32'b011100);
    set_nxt(16'h0300, 17'd2000);
    tick();
    chk("pf2_flags", flags(), 32'b101100);
    chk("pf2_dst", 32'(bus.pf_dst), 32'd0);
    chk("pf2_count", 32'(bus.pf_count), 32'd2000);
    // layer finishes 10 cycles before its successor's preload
    tick();
    bus.layer_done = 1; tick(); bus.layer_done = 0;
    chk("drain_enter", flags(), 32'b101100);
    n_start = 0;
    for (int i = 0; i < 9; i++) begin
      bus.layer_done = (i == 4);
      tick();
      n_start += int'(bus.exec_start);
    end
    bus.layer_done = 0;
    chk("drain_no_start", 32'(n_start), 32'd0);
    bus.pf_done = 1; tick(); bus.pf_done = 0;
    chk("drain_exit", flags(), 32'b010100);
    set_nxt(16'h0400, 17'd0);
    // DW layer with weightless AP next: no preload
    n_start = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_start += int'(bus.pf_req);
    end
    chk("dw_no_pf_req", 32'(n_start), 32'd0);
    bus.layer_done = 1; tick(); bus.layer_done = 0;
    chk("ap_start_same_half", flags(), 32'b010100);
    set_nxt(16'h0500, 17'd5000);
    tick();
    chk("fc_pf_flags", flags(), 32'b100101);
    chk("fc_pf_count_clamp", 32'(bus.pf_count), 32'd4096);
    chk("fc_pf_dst", 32'(bus.pf_dst), 32'd4096);
    repeat (2) tick();
    bus.layer_done = 1; bus.pf_done = 1; tick(); bus.layer_done = 0; bus.pf_done = 0;
    chk("coincident_start", flags(), 32'b011101);
    bus.last_layer = 1; set_nxt(16'h0, 17'd0);
    tick();
    chk("last_no_pf", flags(), 32'b001101);
    bus.layer_done = 1; tick(); bus.layer_done = 0;
    chk("fin_done", flags(), 32'b001011);
    tick();
    chk("idle_after_fin", flags(), 32'b001001);
    bus.last_layer = 0;
    // reset in the middle of a fill
    bus.cur_w_base = 16'h0600; bus.cur_w_count = 17'd100;
    bus.run_start = 1; tick(); bus.run_start = 0;
    chk("fill2_req", flags(), 32'b100101);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_flags", flags(), 32'h0);
    chk("async_reset_count", 32'(bus.pf_count), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.pf_done = 1; tick(); bus.pf_done = 0;
    tick();
    chk("spurious_pf_done", flags(), 32'h0);
    // weightless first layer skips FILL
    bus.cur_w_count = 17'd0; bus.last_layer = 1;
    bus.run_start = 1; tick(); bus.run_start = 0;
    chk("zero_cur_start", flags(), 32'b010100);
    bus.layer_done = 1; tick(); bus.layer_done = 0;
    chk("zero_cur_fin", flags(), 32'b000010);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
